// File: rtl/norm_shift_11.sv
// norm_shift_11: iterative left-shift normalizer, 11-bit mantissa, 8-bit exponent.
// Optional NORM_SHIFT4_EN: take 4-bit steps when enough leading zeros and exponent remain.
module norm_shift_11 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_mant,
    input  logic [7:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_mant,
    output logic [7:0]  out_exp,
    output logic [3:0]  out_shift,
    output logic        out_zero,
    output logic        out_denorm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] mant_q,  mant_d;
    logic [7:0]  exp_q,   exp_d;
    logic [3:0]  shift_q, shift_d;
    logic        zero_q,  zero_d;
    logic        denorm_q, denorm_d;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            shift_q  <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            shift_q  <= shift_d;
            zero_q   <= zero_d;
            denorm_q <= denorm_d;
        end
    end

    // Next-state, datapath update and handshake decode.
    always_comb begin
        state_d   = state_q;
        mant_d    = mant_q;
        exp_d     = exp_q;
        shift_d   = shift_q;
        zero_d    = zero_q;
        denorm_d  = denorm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mant_d   = in_mant;
                    exp_d    = in_exp;
                    shift_d  = 4'd0;
                    zero_d   = 1'b0;
                    denorm_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q == 11'd0) begin
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else if (mant_q[10]) begin
                    state_d = DONE;
                end else if (exp_q == 8'd0) begin
                    denorm_d = 1'b1;
                    state_d  = DONE;
`ifdef NORM_SHIFT4_EN
                end else if (mant_q[10:7] == 4'd0 && exp_q >= 8'd4) begin
                    mant_d  = {mant_q[6:0], 4'b0000};
                    exp_d   = exp_q - 8'd4;
                    shift_d = shift_q + 4'd4;
`endif
                end else begin
                    mant_d  = {mant_q[9:0], 1'b0};
                    exp_d   = exp_q - 8'd1;
                    shift_d = shift_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_mant   = mant_q;
    assign out_exp    = exp_q;
    assign out_shift  = shift_q;
    assign out_zero   = zero_q;
    assign out_denorm = denorm_q;

endmodule

// File: tb/tb_norm_shift_11.sv
// tb_norm_shift_11: randomized and directed checks of norm_shift_11
// against a leading-zero-count reference model.
module tb_norm_shift_11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_mant;
    logic [7:0]  out_exp;
    logic [3:0]  out_shift;
    logic        out_zero;
    logic        out_denorm;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    norm_shift_11 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_shift (out_shift),
        .out_zero  (out_zero),
        .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] obs();
        return {out_mant, out_exp, out_shift, out_zero, out_denorm};
    endfunction

    // Reference: count leading zeros, stop early if exponent runs out.
    task automatic model(input logic [10:0] m, input logic [7:0] e,
                         output logic [24:0] vec, output int lat);
        int lz, k, steps;
        logic [10:0] rm;
        if (m == 11'd0) begin
            vec = {11'd0, e, 4'd0, 1'b1, 1'b0};
            lat = 1;
        end else begin
            lz = 0;
            while (m[10 - lz] == 1'b0) lz++;
            k = (lz < int'(e)) ? lz : int'(e);
            rm = m << k;
`ifdef NORM_SHIFT4_EN
            steps = k / 4 + k % 4;
`else
            steps = k;
`endif
            vec = {rm, 8'(int'(e) - k), 4'(k), 1'b0, (lz > int'(e))};
            lat = 1 + steps;
        end
    endtask

    // Drive one input, return the number of edges from accept to out_valid.
    task automatic apply(input logic [10:0] m, input logic [7:0] e,
                         output int lat);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs() !== 25'd0) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b vec=%h, want rdy=1 vld=0 vec=0",
                     in_ready, out_valid, obs());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [10:0] ms [6];
        logic [7:0]  es [6];
        logic [24:0] ev;
        int el, lat;
        ms = '{11'h400, 11'h001, 11'h000, 11'h020, 11'h7FF, 11'h001};
        es = '{8'd100,  8'd50,   8'd77,   8'd3,    8'd0,    8'd0};
        for (int i = 0; i < 6; i++) begin
            model(ms[i], es[i], ev, el);
            apply(ms[i], es[i], lat);
            tests++;
            if (obs() !== ev) begin
                fails++;
                $display("FAIL directed[%0d] result: got %h want %h", i, obs(), ev);
            end
            tests++;
            if (lat !== el) begin
                fails++;
                $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, el);
            end
            drain();
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [24:0] ev;
        ev = {11'h400, 8'd8, 4'd1, 1'b0, 1'b0};
        apply(11'h200, 8'd9, lat);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (obs() !== ev || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: vec=%h vld=%b rdy=%b want vec=%h vld=1 rdy=0",
                         i, obs(), out_valid, in_ready, ev);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold release: vld=%b rdy=%b want vld=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat, el;
        logic [24:0] ev;
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 11'h001;
        in_exp   = 8'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: vld=%b rdy=%b want vld=0 rdy=1",
                     out_valid, in_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid release: vld=%b rdy=%b want vld=0 rdy=1",
                     out_valid, in_ready);
        end
        model(11'h400, 8'd5, ev, el);
        apply(11'h400, 8'd5, lat);
        tests++;
        if (obs() !== ev || lat !== el) begin
            fails++;
            $display("FAIL reset_mid next: vec=%h lat=%0d want vec=%h lat=%0d",
                     obs(), lat, ev, el);
        end
        drain();
    endtask

    task automatic test_random();
        logic [10:0] m;
        logic [7:0]  e;
        logic [24:0] ev;
        int el, lat;
        for (int i = 0; i < 60; i++) begin
            m = 11'($urandom) >> $urandom_range(0, 11);
            if ($urandom_range(0, 3) != 0) e = 8'($urandom_range(0, 12));
            else e = 8'($urandom_range(0, 255));
            model(m, e, ev, el);
            apply(m, e, lat);
            tests++;
            if (obs() !== ev || lat !== el) begin
                fails++;
                $display("FAIL random[%0d] m=%h e=%0d: vec=%h lat=%0d want vec=%h lat=%0d",
                         i, m, e, obs(), lat, ev, el);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] m;
        logic [7:0]  e;
        logic [24:0] ev;
        int el, prev_t, prev_lat, t, w;
        prev_t = 0;
        prev_lat = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            m = 11'($urandom) >> $urandom_range(0, 11);
            e = 8'($urandom_range(0, 14));
            model(m, e, ev, el);
            @(negedge clk);
            in_valid = 1'b1;
            in_mant  = m;
            in_exp   = e;
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            @(posedge clk);
            #1;
            t = cyc;
            if (i > 0) begin
                tests++;
                if (t - prev_t !== prev_lat + 2) begin
                    fails++;
                    $display("FAIL b2b[%0d] period: got %0d want %0d",
                             i, t - prev_t, prev_lat + 2);
                end
            end
            prev_t = t;
            prev_lat = el;
            w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            tests++;
            if (out_valid !== 1'b1 || obs() !== ev) begin
                fails++;
                $display("FAIL b2b[%0d] result: vld=%b vec=%h want vld=1 vec=%h",
                         i, out_valid, obs(), ev);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
